// File: rtl/carry_look_ahead_16bit.sv
// Two-level 16-bit carry-look-ahead adder: four 4-bit CLA groups plus a
// second-level look-ahead unit, with sum/cout captured in flops every cycle.

module cla_group4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       c_in,
  output logic [3:0] c,
  output logic       gg,
  output logic       pg
);
  // c[k] is the carry into bit k of this nibble, flattened to sum-of-products.
  always_comb begin
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_in);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
    pg   = p[3] & p[2] & p[1] & p[0];
  end
endmodule

module cla_lookahead_unit (
  input  logic [3:0] gg,
  input  logic [3:0] pg,
  input  logic       c0,
  output logic       c4,
  output logic       c8,
  output logic       c12,
  output logic       c16
);
  // Each group carry is derived from c0 and group terms only, never from
  // another group's carry, so there is no nibble-to-nibble ripple.
  always_comb begin
    c4  = gg[0] | (pg[0] & c0);
    c8  = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & c0);
    c12 = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
        | (pg[2] & pg[1] & pg[0] & c0);
    c16 = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
        | (pg[3] & pg[2] & pg[1] & gg[0])
        | (pg[3] & pg[2] & pg[1] & pg[0] & c0);
  end
endmodule

module carry_look_ahead_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [3:0]  grp_cin;
  logic        c16;

  logic [15:0] sum_d;
  logic [15:0] sum_q;
  logic        cout_d;
  logic        cout_q;

  always_comb begin
    g = a & b;
    p = a ^ b;
  end

  cla_lookahead_unit u_lookahead (
    .gg  (grp_g),
    .pg  (grp_p),
    .c0  (cin),
    .c4  (grp_cin[1]),
    .c8  (grp_cin[2]),
    .c12 (grp_cin[3]),
    .c16 (c16)
  );

  assign grp_cin[0] = cin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_group
    cla_group4 u_group (
      .g    (g[gi*4 +: 4]),
      .p    (p[gi*4 +: 4]),
      .c_in (grp_cin[gi]),
      .c    (c[gi*4 +: 4]),
      .gg   (grp_g[gi]),
      .pg   (grp_p[gi])
    );
  end

  always_comb begin
    sum_d  = p ^ c;
    cout_d = c16;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= 16'h0000;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_carry_look_ahead_16bit.sv
// Self-checking bench for carry_look_ahead_16bit: directed vector table,
// reset sequences, and back-to-back random operands against an arithmetic model.

module tb_carry_look_ahead_16bit;
  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;

  int checks;
  int errors;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t        vecs[$];
  logic [16:0] exp_q[$];

  carry_look_ahead_16bit dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci);
    logic [16:0] r;
    r = {1'b0, x} + {1'b0, y} + {16'b0, ci};
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] exp_sum, input logic exp_cout);
    checks++;
    if (sum !== exp_sum || cout !== exp_cout) begin
      errors++;
      $display("FAIL %s: got sum=%h cout=%b, expected sum=%h cout=%b",
               name, sum, cout, exp_sum, exp_cout);
    end
  endtask

  // driver task: applies operands at the falling edge
  task automatic drive(input logic r, input logic [15:0] x, input logic [15:0] y,
                       input logic ci);
    @(negedge clk);
    rst = r;
    a   = x;
    b   = y;
    cin = ci;
  endtask

  task automatic add_vec(input string n, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic [15:0] s, input logic co);
    vec_t v;
    v.name = n; v.a = x; v.b = y; v.cin = ci; v.exp_sum = s; v.exp_cout = co;
    vecs.push_back(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; a = 16'h0; b = 16'h0; cin = 1'b0;

    add_vec("zero",        16'd0,     16'd0,     1'b0, 16'd0,     1'b0);
    add_vec("a_max",       16'd65535, 16'd0,     1'b0, 16'd65535, 1'b0);
    add_vec("b_max",       16'd0,     16'd65535, 1'b0, 16'd65535, 1'b0);
    add_vec("both_max",    16'd65535, 16'd65535, 1'b0, 16'd65534, 1'b1);
    add_vec("alt_aaaa",    16'd43690, 16'd43690, 1'b0, 16'd21844, 1'b1);
    add_vec("max_cin",     16'hFFFF,  16'hFFFF,  1'b1, 16'hFFFF,  1'b1);
    add_vec("prop_all",    16'hFFFF,  16'h0000,  1'b1, 16'h0000,  1'b1);
    add_vec("nibble_chain",16'h0FFF,  16'h0001,  1'b0, 16'h1000,  1'b0);
    add_vec("grp1_prop",   16'h00F0,  16'h000F,  1'b1, 16'h0100,  1'b0);
    add_vec("mid_carry",   16'h7FFF,  16'h0001,  1'b0, 16'h8000,  1'b0);
    for (int i = 0; i < 16; i++) begin
      add_vec($sformatf("sweep_a%0d", i),  16'(i), 16'd10, 1'b0, 16'(i + 10), 1'b0);
      add_vec($sformatf("sweep_b%0d", i),  16'd10, 16'(i), 1'b0, 16'(i + 10), 1'b0);
      add_vec($sformatf("sweep_ab%0d", i), 16'(i), 16'(i), 1'b0, 16'(2 * i),  1'b0);
    end

    // Reset with operands present, then release
    drive(1'b1, 16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    check("reset_state", 16'h0000, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset", 16'h2345, 1'b0);

    foreach (vecs[k]) begin
      drive(1'b0, vecs[k].a, vecs[k].b, vecs[k].cin);
      @(negedge clk);
      check(vecs[k].name, vecs[k].exp_sum, vecs[k].exp_cout);
    end

    // Output holds across the whole cycle after its capture edge
    drive(1'b0, 16'hFFFF, 16'h0000, 1'b1);
    @(posedge clk);
    #1;
    a = 16'h0001; b = 16'h0001; cin = 1'b0;
    #3;
    check("hold_between_edges", 16'h0000, 1'b1);

    // Mid-stream reset discards the operands at the reset edge
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b1);
    @(negedge clk);
    check("reset_priority", 16'h0000, 1'b0);
    drive(1'b0, 16'h8000, 16'h8000, 1'b1);
    @(negedge clk);
    check("after_midreset", 16'h0001, 1'b1);

    // Back-to-back random operands with a scoreboard queue
    for (int n = 0; n < 10000; n++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      logic [16:0] exp;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check("random", exp[15:0], exp[16]);
      end
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rc = 1'($urandom_range(0, 1));
      a = ra; b = rb; cin = rc;
      exp_q.push_back(model_add(ra, rb, rc));
    end
    begin
      logic [16:0] exp;
      @(negedge clk);
      exp = exp_q.pop_front();
      check("random_last", exp[15:0], exp[16]);
    end

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
